pc_seq_hold: RTL and testbench

- Sequential-PC hold path for the fetch stage.
- Adds a constant 4 to the incoming program counter.
- Selects between that incremented value and the previously latched value, and latches the selection into a pipeline register on each clock.
- Provides the PC+4 value handed to stage 2, which can be frozen by a pause input.

---
 rtl/pc_seq_pkg.sv | 9 +
 rtl/add_const.sv | 13 +
 rtl/mux2_w.sv | 14 +
 rtl/reg_sync_clr.sv | 20 ++
 rtl/pc_seq_hold.sv | 47 ++++
 tb/tb_pc_seq_hold.sv | 136 +++++++++++++
 6 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage sequential-PC path.
package pc_seq_pkg;

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned PC_INC   = 4;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage : pc_seq_pkg

// File: rtl/add_const.sv
// Combinational adder of a fixed constant; carry out is dropped (mod 2^WIDTH).
module add_const #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INC   = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum
);

  // Wrap-around increment; low bits below log2(INC) pass straight through.
  assign sum = a + WIDTH'(INC);

endmodule : add_const

// File: rtl/mux2_w.sv
// Two-input word mux; sel = 1 chooses in1. No default on X/Z select.
module mux2_w #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  // Plain ternary so an unknown select propagates as unknown.
  assign out = sel ? in1 : in0;

endmodule : mux2_w

// File: rtl/reg_sync_clr.sv
// Word register with synchronous active-high clear; shared by fetch pipeline regs.
module reg_sync_clr #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over data; no enable, holding is done by the caller's feedback.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule : reg_sync_clr

// File: rtl/pc_seq_hold.sv
// Fetch-stage PC+INC path: increments pc, optionally holds the latched value
// under pause, and registers the selection for stage 2.
module pc_seq_hold
  import pc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH,
  parameter int unsigned INC   = PC_INC
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] pc,
  input  logic             pause,
  output logic [WIDTH-1:0] pc_inc,
  output logic [WIDTH-1:0] pc_sel,
  output logic [WIDTH-1:0] pc_q
);

  // Sequential next PC.
  add_const #(
    .WIDTH (WIDTH),
    .INC   (INC)
  ) u_add (
    .a   (pc),
    .sum (pc_inc)
  );

  // Hold path: pause feeds the latched value back into the register.
  mux2_w #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel (pause),
    .in0 (pc_inc),
    .in1 (pc_q),
    .out (pc_sel)
  );

  // Pipeline register handed to stage 2.
  reg_sync_clr #(
    .WIDTH (WIDTH)
  ) u_reg (
    .clk (clk),
    .clr (clr),
    .d   (pc_sel),
    .q   (pc_q)
  );

endmodule : pc_seq_hold

// File: tb/tb_pc_seq_hold.sv
// Directed-vector and random-model bench for pc_seq_hold.
module tb_pc_seq_hold;

  localparam int unsigned W = 32;

  logic         clk;
  logic         clr;
  logic [W-1:0] pc;
  logic         pause;
  logic [W-1:0] pc_inc;
  logic [W-1:0] pc_sel;
  logic [W-1:0] pc_q;

  int n_chk = 0;
  int n_err = 0;

  pc_seq_hold #(
    .WIDTH (W),
    .INC   (4)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .pc     (pc),
    .pause  (pause),
    .pc_inc (pc_inc),
    .pc_sel (pc_sel),
    .pc_q   (pc_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         clr;
    logic         pause;
    logic [W-1:0] pc;
    logic [W-1:0] exp_inc;
    logic [W-1:0] exp_sel;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int idx,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  logic [W-1:0] m_q;
  logic [W-1:0] m_inc;
  logic [W-1:0] hold_v;

  initial begin
    clr   = 1'b0;
    pause = 1'b0;
    pc    = '0;

    //             clr   pause pc            inc           sel           q after edge
    vecs[0]  = '{1'b1, 1'b0, 32'h12345678, 32'h1234567C, 32'h1234567C, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b1, 32'h12345678, 32'h1234567C, 32'h00000000, 32'h00000000};
    vecs[2]  = '{1'b0, 1'b0, 32'h00000100, 32'h00000104, 32'h00000104, 32'h00000104};
    vecs[3]  = '{1'b0, 1'b0, 32'h00000104, 32'h00000108, 32'h00000108, 32'h00000108};
    vecs[4]  = '{1'b0, 1'b1, 32'h00000200, 32'h00000204, 32'h00000108, 32'h00000108};
    vecs[5]  = '{1'b0, 1'b1, 32'h00000200, 32'h00000204, 32'h00000108, 32'h00000108};
    vecs[6]  = '{1'b0, 1'b1, 32'h00000200, 32'h00000204, 32'h00000108, 32'h00000108};
    vecs[7]  = '{1'b0, 1'b0, 32'h00000200, 32'h00000204, 32'h00000204, 32'h00000204};
    vecs[8]  = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[9]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000003, 32'h00000003, 32'h00000003};
    vecs[10] = '{1'b0, 1'b0, 32'h00000003, 32'h00000007, 32'h00000007, 32'h00000007};
    vecs[11] = '{1'b0, 1'b0, 32'hABCCFFFC, 32'hABCD0000, 32'hABCD0000, 32'hABCD0000};
    vecs[12] = '{1'b1, 1'b1, 32'h00000055, 32'h00000059, 32'hABCD0000, 32'h00000000};
    vecs[13] = '{1'b0, 1'b1, 32'h00000077, 32'h0000007B, 32'h00000000, 32'h00000000};
    vecs[14] = '{1'b0, 1'b0, 32'h00000077, 32'h0000007B, 32'h0000007B, 32'h0000007B};

    // Directed table: drive on the falling edge, check comb outputs, then the register.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      clr   = vecs[i].clr;
      pause = vecs[i].pause;
      pc    = vecs[i].pc;
      #1;
      check("pc_inc", i, pc_inc, vecs[i].exp_inc);
      check("pc_sel", i, pc_sel, vecs[i].exp_sel);
      @(posedge clk);
      #1;
      check("pc_q", i, pc_q, vecs[i].exp_q);
    end

    // clr pulsed only between edges must not disturb the register.
    @(negedge clk);
    pause = 1'b1;
    pc    = 32'h00000300;
    clr   = 1'b1;
    #2;
    clr   = 1'b0;
    #1;
    check("clr_mid_q", 0, pc_q, 32'h0000007B);
    @(posedge clk);
    #1;
    check("clr_mid_q", 1, pc_q, 32'h0000007B);

    // Pause release picks up the current pc, not the held value.
    @(negedge clk);
    pause = 1'b0;
    pc    = 32'h00000400;
    @(posedge clk);
    #1;
    check("release_q", 0, pc_q, 32'h00000404);

    // Randomised traffic against a simple reference model.
    m_q = pc_q === 32'h00000404 ? 32'h00000404 : 32'h00000404;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      pc    = $urandom;
      pause = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 99) < 5);
      #1;
      m_inc  = pc + 32'd4;
      hold_v = pause ? m_q : m_inc;
      check("rnd_inc", c, pc_inc, m_inc);
      check("rnd_sel", c, pc_sel, hold_v);
      @(posedge clk);
      m_q = clr ? '0 : hold_v;
      #1;
      check("rnd_q", c, pc_q, m_q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule : tb_pc_seq_hold
